bitplane_ram_writer: RTL and testbench



---
 rtl/bitplane_ram_writer.sv | 157 +++++++++++++++
 tb/tb_bitplane_ram_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitplane_ram_writer.sv
// Writes nine-word bitplane groups into subband-ordered regions of a 4096x16 coefficient RAM.
// Optional macro BITPLANE_RAM_WRITER_ERR_EN enables illegal subband code detection.
module bitplane_ram_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bitplane_input_valid,
  output logic        bitplane_input_ready,
  input  logic [2:0]  subband,
  input  logic [15:0] bitplane_data0,
  input  logic [15:0] bitplane_data1,
  input  logic [15:0] bitplane_data2,
  input  logic [15:0] bitplane_data3,
  input  logic [15:0] bitplane_data4,
  input  logic [15:0] bitplane_data5,
  input  logic [15:0] bitplane_data6,
  input  logic [15:0] bitplane_data7,
  input  logic [15:0] bitplane_data8,
  output logic [11:0] ram_write_address,
  output logic [15:0] ram_data_output,
  output logic        ram_write_en,
  output logic        frame_done,
  output logic        subband_error
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  state_e      state_q;
  logic [15:0] words_q [8];
  logic [3:0]  k_q;
  logic [1:0]  region_q;
  logic [11:0] ptr_q [4];

  function automatic logic [11:0] baseOf(input logic [1:0] r);
    case (r)
      2'd0:    baseOf = 12'd0;
      2'd1:    baseOf = 12'd64;
      2'd2:    baseOf = 12'd256;
      default: baseOf = 12'd1024;
    endcase
  endfunction

  function automatic logic [11:0] sizeOf(input logic [1:0] r);
    case (r)
      2'd0:    sizeOf = 12'd64;
      2'd1:    sizeOf = 12'd192;
      2'd2:    sizeOf = 12'd768;
      default: sizeOf = 12'd3072;
    endcase
  endfunction

  logic [1:0] inRegion;
  logic       inIllegal;

`ifdef BITPLANE_RAM_WRITER_ERR_EN
  assign inRegion  = subband[1:0];
  assign inIllegal = subband[2];
`else
  assign inRegion  = subband[2] ? 2'd3 : subband[1:0];
  assign inIllegal = 1'b0;
`endif

  // The word presented by the outputs in the next cycle: word 0 comes straight
  // from the inputs at the accept edge, later words from the captured group.
  logic [1:0]  selRegion;
  logic [15:0] selWord;
  logic [11:0] selPtr;
  logic        selRoom;
  logic [11:0] selAddr;
  logic        allFull;

  always_comb begin
    selRegion = (state_q == WRITE) ? region_q : inRegion;
    selWord   = (state_q == WRITE) ? words_q[k_q[2:0]] : bitplane_data0;
    selPtr    = ptr_q[selRegion];
    selRoom   = selPtr < sizeOf(selRegion);
    selAddr   = baseOf(selRegion) + selPtr;
    allFull   = (ptr_q[0] == sizeOf(2'd0)) && (ptr_q[1] == sizeOf(2'd1)) &&
                (ptr_q[2] == sizeOf(2'd2)) && (ptr_q[3] == sizeOf(2'd3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      bitplane_input_ready <= 1'b1;
      ram_write_address    <= 12'd0;
      ram_data_output      <= 16'd0;
      ram_write_en         <= 1'b0;
      frame_done           <= 1'b0;
      subband_error        <= 1'b0;
      k_q                  <= 4'd0;
      region_q             <= 2'd0;
      for (int i = 0; i < 8; i++) words_q[i] <= 16'd0;
      for (int i = 0; i < 4; i++) ptr_q[i] <= 12'd0;
    end else begin
      ram_write_en  <= 1'b0;
      frame_done    <= 1'b0;
      subband_error <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bitplane_input_valid) begin
            if (inIllegal) begin
              subband_error <= 1'b1;
            end else begin
              words_q[0]           <= bitplane_data1;
              words_q[1]           <= bitplane_data2;
              words_q[2]           <= bitplane_data3;
              words_q[3]           <= bitplane_data4;
              words_q[4]           <= bitplane_data5;
              words_q[5]           <= bitplane_data6;
              words_q[6]           <= bitplane_data7;
              words_q[7]           <= bitplane_data8;
              region_q             <= inRegion;
              k_q                  <= 4'd0;
              state_q              <= WRITE;
              bitplane_input_ready <= 1'b0;
              if (selRoom) begin
                ram_write_en       <= 1'b1;
                ram_write_address  <= selAddr;
                ram_data_output    <= selWord;
                ptr_q[selRegion]   <= selPtr + 12'd1;
              end
            end
          end
        end
        WRITE: begin
          if (k_q == 4'd8) begin
            if (allFull) begin
              state_q    <= DONE;
              frame_done <= 1'b1;
            end else begin
              state_q              <= IDLE;
              bitplane_input_ready <= 1'b1;
            end
          end else begin
            k_q <= k_q + 4'd1;
            if (selRoom) begin
              ram_write_en      <= 1'b1;
              ram_write_address <= selAddr;
              ram_data_output   <= selWord;
              ptr_q[selRegion]  <= selPtr + 12'd1;
            end
          end
        end
        DONE: begin
          for (int i = 0; i < 4; i++) ptr_q[i] <= 12'd0;
          state_q              <= IDLE;
          bitplane_input_ready <= 1'b1;
        end
        default: begin
          state_q              <= IDLE;
          bitplane_input_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitplane_ram_writer.sv
// Self-checking bench for bitplane_ram_writer; honours BITPLANE_RAM_WRITER_ERR_EN when defined.
module tb_bitplane_ram_writer;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [2:0]  subband;
  logic [15:0] dataIn [9];
  logic [11:0] addr;
  logic [15:0] dout;
  logic        we;
  logic        frameDone;
  logic        subErr;

  bitplane_ram_writer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bitplane_input_valid (valid),
    .bitplane_input_ready (ready),
    .subband              (subband),
    .bitplane_data0       (dataIn[0]),
    .bitplane_data1       (dataIn[1]),
    .bitplane_data2       (dataIn[2]),
    .bitplane_data3       (dataIn[3]),
    .bitplane_data4       (dataIn[4]),
    .bitplane_data5       (dataIn[5]),
    .bitplane_data6       (dataIn[6]),
    .bitplane_data7       (dataIn[7]),
    .bitplane_data8       (dataIn[8]),
    .ram_write_address    (addr),
    .ram_data_output      (dout),
    .ram_write_en         (we),
    .frame_done           (frameDone),
    .subband_error        (subErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]  sub;
    logic [15:0] dBase;
    int          expFirst;
    int          expWrites;
  } vec_t;

  exp_t expQ [$];
  int   vectors = 0;
  int   misses = 0;
  int   mPtr [4];
  int   mBase [4] = '{0, 64, 256, 1024};
  int   mSize [4] = '{64, 192, 768, 3072};

  function automatic logic [1:0] mapRegion(input logic [2:0] s);
`ifdef BITPLANE_RAM_WRITER_ERR_EN
    return s[1:0];
`else
    return s[2] ? 2'd3 : s[1:0];
`endif
  endfunction

  function automatic bit isIllegal(input logic [2:0] s);
`ifdef BITPLANE_RAM_WRITER_ERR_EN
    return s[2];
`else
    return (s == 3'd7) && 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      misses++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    checkOutput({tag, "_we"}, 32'(we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(addr), 32'd0);
    checkOutput({tag, "_data"}, 32'(dout), 32'd0);
    checkOutput({tag, "_done"}, 32'(frameDone), 32'd0);
    checkOutput({tag, "_err"}, 32'(subErr), 32'd0);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 4; i++) mPtr[i] = 0;
    expQ.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  // Drives one group and checks every output cycle against the scoreboard;
  // abortAt >= 0 pulls reset during that write cycle.
  task automatic applyStimulus(input logic [2:0] sub, input logic [15:0] dBase, input int abortAt,
                               output int firstAddr, output int nWrites, output int doneSeen);
    exp_t e;
    logic [1:0] r;
    bit illegal;
    bit full;
    firstAddr = -1;
    nWrites = 0;
    doneSeen = 0;
    @(negedge clk);
    checkOutput("ready_before_accept", 32'(ready), 32'd1);
    subband = sub;
    for (int k = 0; k < 9; k++) dataIn[k] = dBase + 16'(k);
    valid = 1'b1;
    illegal = isIllegal(sub);
    r = mapRegion(sub);
    if (!illegal) begin
      for (int k = 0; k < 9; k++) begin
        if (mPtr[r] < mSize[r]) begin
          expQ.push_back({1'b1, 12'(mBase[r] + mPtr[r]), 16'(dBase + 16'(k))});
          mPtr[r]++;
        end else begin
          expQ.push_back({1'b0, 12'd0, 16'd0});
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) dataIn[k] = 16'($urandom);
    subband = 3'($urandom);
    if (illegal) begin
      valid = 1'b0;
      @(negedge clk);
      checkOutput("err_pulse", 32'(subErr), 32'd1);
      checkOutput("err_ready", 32'(ready), 32'd1);
      checkOutput("err_we", 32'(we), 32'd0);
      @(negedge clk);
      checkOutput("err_clear", 32'(subErr), 32'd0);
      checkOutput("err_we2", 32'(we), 32'd0);
      return;
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 8) valid = 1'b0;
      e = expQ.pop_front();
      checkOutput("write_en", 32'(we), 32'(e.we));
      if (e.we) begin
        checkOutput("write_addr", 32'(addr), 32'(e.addr));
        checkOutput("write_data", 32'(dout), 32'(e.data));
        if (firstAddr < 0) firstAddr = int'(addr);
        nWrites++;
      end
      checkOutput("ready_busy", 32'(ready), 32'd0);
      checkOutput("done_busy", 32'(frameDone), 32'd0);
      checkOutput("err_busy", 32'(subErr), 32'd0);
      if (c == abortAt) begin
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        clearModel();
        return;
      end
    end
    full = 1'b1;
    for (int i = 0; i < 4; i++) if (mPtr[i] != mSize[i]) full = 1'b0;
    @(negedge clk);
    checkOutput("done_flag", 32'(frameDone), 32'(full));
    checkOutput("ready_after", 32'(ready), 32'(!full));
    checkOutput("we_after", 32'(we), 32'd0);
    doneSeen = int'(frameDone);
    if (full) begin
      for (int i = 0; i < 4; i++) mPtr[i] = 0;
      @(negedge clk);
      checkOutput("ready_after_done", 32'(ready), 32'd1);
      checkOutput("done_cleared", 32'(frameDone), 32'd0);
    end
  endtask

  vec_t vecs [9];
  int   fa, nw, dn, totalDone, totalWrites;

  initial begin
    rst_n = 1'b1;
    valid = 1'b0;
    subband = 3'd0;
    for (int k = 0; k < 9; k++) dataIn[k] = 16'd0;
    clearModel();

    vecs[0] = '{3'd0, 16'h0100, 0, 9};
    vecs[1] = '{3'd3, 16'h3000, 1024, 9};
    vecs[2] = '{3'd1, 16'h1100, 64, 9};
    vecs[3] = '{3'd3, 16'h3100, 1033, 9};
    vecs[4] = '{3'd1, 16'h1200, 73, 9};
    vecs[5] = '{3'd2, 16'h2000, 256, 9};
`ifdef BITPLANE_RAM_WRITER_ERR_EN
    vecs[6] = '{3'd5, 16'h5000, -1, 0};
    vecs[8] = '{3'd7, 16'h7000, -1, 0};
`else
    vecs[6] = '{3'd5, 16'h5000, 1042, 9};
    vecs[8] = '{3'd7, 16'h7000, 1051, 9};
`endif
    vecs[7] = '{3'd0, 16'h0200, 9, 9};

    resetDut();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].sub, vecs[i].dBase, -1, fa, nw, dn);
      checkOutput("vec_writes", 32'(nw), 32'(vecs[i].expWrites));
      if (vecs[i].expWrites > 0) checkOutput("vec_first", 32'(fa), 32'(vecs[i].expFirst));
    end

    // Region 0 holds 64 words, so the eighth group keeps one word and drops eight.
    resetDut();
    totalWrites = 0;
    for (int g = 0; g < 8; g++) begin
      applyStimulus(3'd0, 16'(16'h0A00 + 16'(g * 16)), -1, fa, nw, dn);
      totalWrites += nw;
    end
    checkOutput("trunc_last_first", 32'(fa), 32'd63);
    checkOutput("trunc_last_writes", 32'(nw), 32'd1);
    checkOutput("trunc_total", 32'(totalWrites), 32'd64);

    resetDut();
    totalDone = 0;
    begin
      int counts [4] = '{8, 22, 86, 342};
      for (int r = 0; r < 4; r++) begin
        for (int g = 0; g < counts[r]; g++) begin
          applyStimulus(3'(r), 16'($urandom), -1, fa, nw, dn);
          totalDone += dn;
        end
      end
    end
    checkOutput("fill_done_last", 32'(dn), 32'd1);
    checkOutput("fill_done_count", 32'(totalDone), 32'd1);
    applyStimulus(3'd0, 16'h0C00, -1, fa, nw, dn);
    checkOutput("after_frame_first", 32'(fa), 32'd0);

    applyStimulus(3'd2, 16'h2D00, 4, fa, nw, dn);
    applyStimulus(3'd0, 16'h0E00, -1, fa, nw, dn);
    checkOutput("after_abort_first", 32'(fa), 32'd0);
    checkOutput("after_abort_writes", 32'(nw), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
